// File: rtl/fifomult_pkg.sv
// fifomult_pkg: shared types and defaults for the fifomult2024 responder.
package fifomult_pkg;

   typedef logic signed [15:0] operand_t;
   typedef logic signed [31:0] product_t;

   typedef struct packed {
      operand_t data;
      logic     perr;
   } entry_t;

   typedef enum logic [1:0] {
      IDLE,
      MULT,
      OUT
   } state_t;

   localparam int unsigned FIFO_DEPTH_DEF   = 8;
   localparam int unsigned MULT_LATENCY_DEF = 2;

   // Parity error of a received word: sender supplies even parity (^data).
   function automatic logic calc_perr(input operand_t data, input logic parity);
      return parity ^ (^data);
   endfunction

endpackage

// File: rtl/fifomult_fifo.sv
// fifomult_fifo: synchronous circular FIFO of entry_t, pushes and pops of
// up to two entries per cycle. Requests beyond the free space (push) or the
// stored entries (pop) are clamped, so the FIFO can never over/underflow.
module fifomult_fifo
   import fifomult_pkg::*;
#(
   parameter int unsigned DEPTH = FIFO_DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [1:0]                 push_num,
   input  entry_t                     wr_data0,
   input  entry_t                     wr_data1,
   input  logic [1:0]                 pop_num,
   output entry_t                     rd_data0,
   output entry_t                     rd_data1,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       full_next,
   output logic                       empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   entry_t          mem_q [DEPTH];
   entry_t          mem_d [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   free_slots;
   logic [1:0]      push_req, pop_req;
   logic [1:0]      push_eff, pop_eff;

   // Clamp requests, update storage, pointers and occupancy.
   always_comb begin
      mem_d      = mem_q;
      free_slots = CW'(DEPTH) - count_q;
      push_req   = push_num[1] ? 2'd2 : {1'b0, push_num[0]};
      pop_req    = pop_num[1]  ? 2'd2 : {1'b0, pop_num[0]};
      push_eff   = (CW'(push_req) > free_slots) ? free_slots[1:0] : push_req;
      pop_eff    = (CW'(pop_req) > count_q)     ? count_q[1:0]    : pop_req;

      if (push_eff != 2'd0) begin
         mem_d[wr_ptr_q] = wr_data0;
      end
      if (push_eff == 2'd2) begin
         mem_d[wr_ptr_q + AW'(1)] = wr_data1;
      end

      // Pointer widths equal log2(DEPTH), so the adds wrap at DEPTH.
      wr_ptr_d = wr_ptr_q + AW'(push_eff);
      rd_ptr_d = rd_ptr_q + AW'(pop_eff);
      count_d  = count_q + CW'(push_eff) - CW'(pop_eff);
   end

   // Pointer and count registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage array; contents are meaningless while count is 0, so no reset.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign rd_data0  = mem_q[rd_ptr_q];
   assign rd_data1  = mem_q[rd_ptr_q + AW'(1)];
   assign count     = count_q;
   assign full      = (count_q == CW'(DEPTH));
   assign full_next = (count_d == CW'(DEPTH));
   assign empty     = (count_q == '0);

endmodule

// File: rtl/fifomult_rx.sv
// fifomult_rx: fifomult2024 responder. Buffers parity-protected operand
// words, pairs them as A then B, and returns the signed 32-bit product.
// Optional feature macro: FIFOMULT_PARITY_CHECK_EN (input parity checking).
module fifomult_rx
   import fifomult_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF,
   parameter int unsigned MULT_LATENCY = MULT_LATENCY_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic signed [15:0] data_in,
   input  logic               data_in_parity,
   input  logic               data_in_valid,
   output logic               busy_out,
   output logic signed [31:0] data_out,
   output logic               data_out_parity,
   output logic               data_out_valid,
   output logic               data_in_parity_error
);

   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned LW = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;

   state_t          state_q, state_d;
   logic [LW-1:0]   lat_cnt_q, lat_cnt_d;
   entry_t          a_q, a_d;
   entry_t          b_q, b_d;
   product_t        dout_q, dout_d;
   logic            dpar_q, dpar_d;
   logic            dvalid_q, dvalid_d;
   logic            perr_out_q, perr_out_d;
   logic            busy_q, busy_d;

   logic            in_perr;
   logic            push;
   logic [1:0]      pop_num;
   entry_t          wr_entry;
   entry_t          rd_data0, rd_data1;
   logic [CW-1:0]   fifo_count;
   logic            fifo_full_next;
   logic            unused_full;
   logic            unused_empty;
   operand_t        a_op, b_op;
   product_t        product;
   logic            pair_err;

`ifdef FIFOMULT_PARITY_CHECK_EN
   assign in_perr = calc_perr(data_in, data_in_parity);
`else
   logic unused_in_parity;
   assign unused_in_parity = data_in_parity;
   assign in_perr          = 1'b0;
`endif

   // Acceptance looks only at the registered busy flag, so a word offered in
   // the same cycle as a pop from a full FIFO is still dropped.
   assign push          = data_in_valid & ~busy_q;
   assign wr_entry.data = data_in;
   assign wr_entry.perr = in_perr;

   fifomult_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_num  ({1'b0, push}),
      .wr_data0  (wr_entry),
      .wr_data1  ('0),
      .pop_num   (pop_num),
      .rd_data0  (rd_data0),
      .rd_data1  (rd_data1),
      .count     (fifo_count),
      .full      (unused_full),
      .full_next (fifo_full_next),
      .empty     (unused_empty)
   );

   // Full-precision signed multiply of the held operands.
   assign a_op     = a_q.data;
   assign b_op     = b_q.data;
   assign product  = product_t'(a_op) * product_t'(b_op);
   assign pair_err = a_q.perr | b_q.perr;

   // Core FSM: pop a pair, wait out the multiplier latency, present result.
   always_comb begin
      state_d    = state_q;
      lat_cnt_d  = lat_cnt_q;
      a_d        = a_q;
      b_d        = b_q;
      dout_d     = dout_q;
      dpar_d     = dpar_q;
      dvalid_d   = 1'b0;
      perr_out_d = perr_out_q;
      pop_num    = 2'd0;
      busy_d     = fifo_full_next;

      case (state_q)
         IDLE: begin
            if (fifo_count >= CW'(2)) begin
               pop_num   = 2'd2;
               a_d       = rd_data0;
               b_d       = rd_data1;
               lat_cnt_d = LW'(MULT_LATENCY - 1);
               state_d   = MULT;
            end
         end
         MULT: begin
            if (lat_cnt_q == '0) begin
               state_d = OUT;
            end else begin
               lat_cnt_d = lat_cnt_q - LW'(1);
            end
         end
         OUT: begin
            dvalid_d   = 1'b1;
            dout_d     = pair_err ? '0 : product;
            dpar_d     = ^dout_d;
            perr_out_d = pair_err;
            state_d    = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, operand and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         lat_cnt_q  <= '0;
         a_q        <= '0;
         b_q        <= '0;
         dout_q     <= '0;
         dpar_q     <= 1'b0;
         dvalid_q   <= 1'b0;
         perr_out_q <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         lat_cnt_q  <= lat_cnt_d;
         a_q        <= a_d;
         b_q        <= b_d;
         dout_q     <= dout_d;
         dpar_q     <= dpar_d;
         dvalid_q   <= dvalid_d;
         perr_out_q <= perr_out_d;
         busy_q     <= busy_d;
      end
   end

   assign busy_out             = busy_q;
   assign data_out             = dout_q;
   assign data_out_parity      = dpar_q;
   assign data_out_valid       = dvalid_q;
   assign data_in_parity_error = perr_out_q;

endmodule
